// File: rtl/color_stabilizer_if.sv
// Sensor-side bundle for color_stabilizer: move-done strobe, raw RGB samples in,
// latched cubestate color codes and status out.
interface color_stabilizer_if;
    logic       motors_done;
    logic       sample_valid;
    logic [7:0] edge_r;
    logic [7:0] edge_g;
    logic [7:0] edge_b;
    logic [7:0] corner_r;
    logic [7:0] corner_g;
    logic [7:0] corner_b;
    logic [2:0] edge_color_sensor;
    logic [2:0] corner_color_sensor;
    logic       color_sensor_stable;
    logic       sensor_fault;

    modport master (
        output motors_done, sample_valid,
        output edge_r, edge_g, edge_b, corner_r, corner_g, corner_b,
        input  edge_color_sensor, corner_color_sensor, color_sensor_stable, sensor_fault
    );

    modport slave (
        input  motors_done, sample_valid,
        input  edge_r, edge_g, edge_b, corner_r, corner_g, corner_b,
        output edge_color_sensor, corner_color_sensor, color_sensor_stable, sensor_fault
    );
endinterface

// File: rtl/color_stabilizer.sv
// Waits out mechanical settling after a move, classifies edge/corner RGB readings and
// reports the color pair once it has held steady for STABLE_COUNT samples.
module color_stabilizer #(
    parameter logic [19:0] SETTLE_CYCLES = 20'd50000,
    parameter int          STABLE_COUNT  = 4,
    parameter int          MAX_SAMPLES   = 64,
    parameter logic [7:0]  WHITE_MIN     = 8'd160,
    parameter logic [7:0]  DARK_MAX      = 8'd24
) (
    input  logic               clock,
    input  logic               reset_n,
    color_stabilizer_if.slave  bus
);

    localparam int MW = $clog2(STABLE_COUNT + 1);
    localparam int SW = $clog2(MAX_SAMPLES + 1);
    localparam logic [MW-1:0] MATCH_DONE   = MW'(STABLE_COUNT);
    localparam logic [SW-1:0] SAMPLE_LIMIT = SW'(MAX_SAMPLES);

    localparam logic [2:0] C_WHITE   = 3'd0;
    localparam logic [2:0] C_ORANGE  = 3'd1;
    localparam logic [2:0] C_GREEN   = 3'd2;
    localparam logic [2:0] C_RED     = 3'd3;
    localparam logic [2:0] C_BLUE    = 3'd4;
    localparam logic [2:0] C_YELLOW  = 3'd5;
    localparam logic [2:0] C_INVALID = 3'd7;

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, REPORT} state_t;

    // Ordered rule list; the first match wins. Products are widened to 10 bits.
    function automatic logic [2:0] classify(input logic [7:0] r, input logic [7:0] g,
                                            input logic [7:0] b);
        logic [7:0] hi;
        logic [7:0] lo;
        logic [9:0] g4;
        logic [9:0] r3;
        logic [9:0] g2;
        logic [9:0] r1;
        hi = (r > g) ? r : g;
        hi = (b > hi) ? b : hi;
        lo = (r < g) ? r : g;
        lo = (b < lo) ? b : lo;
        g4 = {g, 2'b00};
        r3 = {2'b00, r} + {1'b0, r, 1'b0};
        g2 = {1'b0, g, 1'b0};
        r1 = {2'b00, r};
        if (hi < DARK_MAX)          return C_INVALID;
        if (lo >= WHITE_MIN)        return C_WHITE;
        if (b > r && b > g)         return C_BLUE;
        if (g > r && g >= b)        return C_GREEN;
        if (g4 >= r3)               return C_YELLOW;
        if (g2 >= r1)               return C_ORANGE;
        return C_RED;
    endfunction

    state_t          state;
    state_t          next_state;
    logic [19:0]     settle_cnt;
    logic [MW-1:0]   match_cnt;
    logic [SW-1:0]   sample_cnt;
    logic [SW-1:0]   accept_cnt;
    logic [2:0]      edge_class;
    logic [2:0]      corner_class;
    logic [2:0]      s1_edge;
    logic [2:0]      s1_corner;
    logic            s1_valid;
    logic [2:0]      ref_edge;
    logic [2:0]      ref_corner;
    logic [2:0]      edge_out;
    logic [2:0]      corner_out;
    logic            fault;
    logic            do_report;
    logic            do_fault;
    logic            accept;

    assign edge_class   = classify(bus.edge_r, bus.edge_g, bus.edge_b);
    assign corner_class = classify(bus.corner_r, bus.corner_g, bus.corner_b);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // A new move always wins, from any state, and cancels a report about to be made.
    always_comb begin
        next_state = state;
        do_report  = 1'b0;
        do_fault   = 1'b0;
        if (bus.motors_done) begin
            next_state = SETTLE;
        end else begin
            case (state)
                IDLE:   next_state = IDLE;
                SETTLE: if (settle_cnt == SETTLE_CYCLES - 20'd1) next_state = SAMPLE;
                SAMPLE: begin
                    if (match_cnt == MATCH_DONE) begin
                        next_state = REPORT;
                        do_report  = 1'b1;
                    end else if (sample_cnt == SAMPLE_LIMIT) begin
                        next_state = REPORT;
                        do_report  = 1'b1;
                        do_fault   = 1'b1;
                    end
                end
                REPORT: next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
        accept = (state == SAMPLE) && (next_state == SAMPLE) && bus.sample_valid &&
                 (accept_cnt != SAMPLE_LIMIT);
    end

    // Stage 1 registers the class pair; stage 2 folds it into the run-length match.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            settle_cnt <= '0;
            match_cnt  <= '0;
            sample_cnt <= '0;
            accept_cnt <= '0;
            s1_edge    <= '0;
            s1_corner  <= '0;
            s1_valid   <= 1'b0;
            ref_edge   <= '0;
            ref_corner <= '0;
            edge_out   <= '0;
            corner_out <= '0;
            fault      <= 1'b0;
        end else begin
            if (bus.motors_done)      settle_cnt <= '0;
            else if (state == SETTLE) settle_cnt <= settle_cnt + 20'd1;

            if (state != SAMPLE) begin
                match_cnt  <= '0;
                sample_cnt <= '0;
                accept_cnt <= '0;
                s1_valid   <= 1'b0;
            end else begin
                s1_valid <= accept;
                if (accept) begin
                    s1_edge    <= edge_class;
                    s1_corner  <= corner_class;
                    accept_cnt <= accept_cnt + SW'(1);
                end
                if (s1_valid) begin
                    if (sample_cnt != SAMPLE_LIMIT) sample_cnt <= sample_cnt + SW'(1);
                    if (s1_edge == C_INVALID || s1_corner == C_INVALID) begin
                        match_cnt <= '0;
                    end else if ({s1_edge, s1_corner} == {ref_edge, ref_corner} &&
                                 match_cnt != '0) begin
                        if (match_cnt != MATCH_DONE) match_cnt <= match_cnt + MW'(1);
                    end else begin
                        ref_edge   <= s1_edge;
                        ref_corner <= s1_corner;
                        match_cnt  <= MW'(1);
                    end
                end
            end

            if (bus.motors_done) begin
                fault <= 1'b0;
            end else if (do_report) begin
                fault      <= do_fault;
                edge_out   <= do_fault ? s1_edge   : ref_edge;
                corner_out <= do_fault ? s1_corner : ref_corner;
            end
        end
    end

    assign bus.edge_color_sensor   = edge_out;
    assign bus.corner_color_sensor = corner_out;
    assign bus.color_sensor_stable = (state == REPORT);
    assign bus.sensor_fault        = fault;

endmodule

// File: tb/tb_color_stabilizer.sv
// Directed bench for color_stabilizer with a short settle time and small sample budget.
module tb_color_stabilizer;

    localparam int SETTLE = 8;

    localparam logic [23:0] RED    = 24'hC81E1E;
    localparam logic [23:0] BLUE   = 24'h1E1EC8;
    localparam logic [23:0] WHITE  = 24'hDCDCDC;
    localparam logic [23:0] YELLOW = 24'hC8A014;
    localparam logic [23:0] ORANGE = 24'hC86E14;
    localparam logic [23:0] GREEN  = 24'h14C814;
    localparam logic [23:0] DARK   = 24'h0A0A0A;
    localparam logic [23:0] TIE    = 24'h646464;

    logic clock;
    logic reset_n;
    int   check_count;
    int   error_count;
    int   stray_pulses;

    logic [23:0] sweep_rgb  [5] = '{WHITE, YELLOW, ORANGE, GREEN, TIE};
    logic [2:0]  sweep_code [5] = '{3'd0, 3'd5, 3'd1, 3'd2, 3'd5};

    color_stabilizer_if bus ();

    color_stabilizer #(
        .SETTLE_CYCLES(20'd8),
        .STABLE_COUNT (4),
        .MAX_SAMPLES  (8)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [23:0] e, input logic [23:0] c);
        @(negedge clock);
        if (bus.color_sensor_stable) stray_pulses++;
        bus.sample_valid = 1'b1;
        bus.edge_r   = e[23:16];
        bus.edge_g   = e[15:8];
        bus.edge_b   = e[7:0];
        bus.corner_r = c[23:16];
        bus.corner_g = c[15:8];
        bus.corner_b = c[7:0];
    endtask

    task automatic sendRun(input logic [23:0] e, input logic [23:0] c, input int n);
        for (int i = 0; i < n; i++) applyStimulus(e, c);
    endtask

    // Leaves the next applyStimulus landing on the first SAMPLE cycle, or `early` cycles sooner.
    task automatic armMotors(input int early);
        @(negedge clock);
        if (bus.color_sensor_stable) stray_pulses++;
        bus.sample_valid = 1'b0;
        bus.motors_done  = 1'b1;
        @(negedge clock);
        if (bus.color_sensor_stable) stray_pulses++;
        bus.motors_done = 1'b0;
        for (int i = 0; i < SETTLE - 1 - early; i++) begin
            @(negedge clock);
            if (bus.color_sensor_stable) stray_pulses++;
        end
    endtask

    task automatic expectPulse(input string tag, input int exp_edge, input int exp_corner,
                               input int exp_fault);
        int first;
        int count;
        int got_edge;
        int got_corner;
        int got_fault;
        first = 0;
        count = 0;
        got_edge = 0;
        got_corner = 0;
        got_fault = 0;
        checkOutput({tag, "_early_pulse"}, stray_pulses, 0);
        stray_pulses = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clock);
            bus.sample_valid = 1'b0;
            if (bus.color_sensor_stable) begin
                count++;
                if (first == 0) begin
                    first      = i;
                    got_edge   = 32'(bus.edge_color_sensor);
                    got_corner = 32'(bus.corner_color_sensor);
                    got_fault  = 32'(bus.sensor_fault);
                end
            end
        end
        checkOutput({tag, "_latency"}, first, 3);
        checkOutput({tag, "_width"}, count, 1);
        checkOutput({tag, "_edge"}, got_edge, exp_edge);
        checkOutput({tag, "_corner"}, got_corner, exp_corner);
        checkOutput({tag, "_fault"}, got_fault, exp_fault);
    endtask

    task automatic expectNoPulse(input string tag, input int cycles);
        int count;
        count = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            bus.sample_valid = 1'b0;
            if (bus.color_sensor_stable) count++;
        end
        checkOutput({tag, "_no_pulse"}, count, 0);
    endtask

    initial begin
        check_count      = 0;
        error_count      = 0;
        stray_pulses     = 0;
        bus.motors_done  = 1'b0;
        bus.sample_valid = 1'b0;
        bus.edge_r = '0; bus.edge_g = '0; bus.edge_b = '0;
        bus.corner_r = '0; bus.corner_g = '0; bus.corner_b = '0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        checkOutput("reset_edge", 32'(bus.edge_color_sensor), 0);
        checkOutput("reset_corner", 32'(bus.corner_color_sensor), 0);
        checkOutput("reset_stable", 32'(bus.color_sensor_stable), 0);
        checkOutput("reset_fault", 32'(bus.sensor_fault), 0);
        @(negedge clock);
        reset_n = 1'b1;

        $display("[TB] basic red/blue");
        armMotors(0);
        sendRun(RED, BLUE, 4);
        expectPulse("basic", 3, 4, 0);

        $display("[TB] classification sweep");
        for (int i = 0; i < 5; i++) begin
            armMotors(0);
            sendRun(sweep_rgb[i], BLUE, 4);
            expectPulse($sformatf("sweep%0d", i), 32'(sweep_code[i]), 4, 0);
        end

        $display("[TB] dark samples");
        armMotors(0);
        sendRun(DARK, BLUE, 6);
        expectNoPulse("dark", 6);

        $display("[TB] G,G,R,R,R,R");
        armMotors(0);
        sendRun(GREEN, BLUE, 2);
        sendRun(RED, BLUE, 4);
        expectPulse("ggrrrr", 3, 4, 0);

        $display("[TB] dark sample mid-run");
        armMotors(0);
        sendRun(ORANGE, GREEN, 2);
        applyStimulus(DARK, GREEN);
        sendRun(ORANGE, GREEN, 4);
        expectPulse("darkgap", 1, 2, 0);

        $display("[TB] timeout");
        armMotors(0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(RED, BLUE);
            applyStimulus(BLUE, BLUE);
        end
        expectPulse("timeout", 4, 4, 1);
        checkOutput("fault_hold", 32'(bus.sensor_fault), 1);

        $display("[TB] restart during sample");
        armMotors(0);
        checkOutput("fault_clear", 32'(bus.sensor_fault), 0);
        checkOutput("edge_held", 32'(bus.edge_color_sensor), 4);
        sendRun(RED, BLUE, 3);
        armMotors(1);
        applyStimulus(RED, BLUE);
        sendRun(RED, BLUE, 1);
        expectNoPulse("restart_partial", 5);
        sendRun(RED, BLUE, 3);
        expectPulse("restart", 3, 4, 0);

        $display("[TB] async reset mid-settle");
        @(negedge clock);
        bus.motors_done = 1'b1;
        @(negedge clock);
        bus.motors_done = 1'b0;
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("areset_edge", 32'(bus.edge_color_sensor), 0);
        checkOutput("areset_corner", 32'(bus.corner_color_sensor), 0);
        checkOutput("areset_stable", 32'(bus.color_sensor_stable), 0);
        @(negedge clock);
        reset_n = 1'b1;
        sendRun(RED, BLUE, 5);
        expectNoPulse("idle_samples", 12);
        checkOutput("stray_end", stray_pulses, 0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/color_stabilizer.md
# color_stabilizer

Upstream of `determine_state`. Once a cube move finishes, this block waits a fixed mechanical settle time. It then classifies the raw RGB readings from the edge and corner sensors into the 3-bit cubestate color codes. When both classifications have held steady for a run of consecutive samples, it reports them with a single-cycle `color_sensor_stable` pulse. `determine_state` takes that pulse as permission to observe `edge_color_sensor`/`corner_color_sensor`.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 20'd50000: clocks to wait after `motors_done` before sampling.
- `STABLE_COUNT`, default 4: consecutive identical valid sample pairs required.
- `MAX_SAMPLES`, default 64: accepted samples before timeout.
- `WHITE_MIN`, default 8'd160: minimum channel value (all channels) for White.
- `DARK_MAX`, default 8'd24: a sample whose max channel is below this is invalid (gap or sticker edge).

Ports:
- `clock` in 1: system clock. One clock; reset is asynchronous and active-low.
- `reset_n` in 1: asynchronous, active-low reset.
- `motors_done` in 1: one-cycle pulse when a move completes; arms the block.
- `sample_valid` in 1: RGB inputs valid this cycle.
- `edge_r`, `edge_g`, `edge_b` in 8 each: edge sensor channels.
- `corner_r`, `corner_g`, `corner_b` in 8 each: corner sensor channels.
- `edge_color_sensor` out 3: latched edge color code.
- `corner_color_sensor` out 3: latched corner color code.
- `color_sensor_stable` out 1: one-cycle pulse; the color outputs are valid in the same cycle.
- `sensor_fault` out 1: timeout flag; stays set until the next `motors_done`.

## Operation
- Color codes: W=0, O=1, G=2, R=3, B=4, Y=5. Invalid is 7 internally and never output on success.
- Classifier is combinational, applied to each sensor. Take the first rule that matches:
  1. max(r,g,b) < DARK_MAX → invalid.
  2. min(r,g,b) ≥ WHITE_MIN → W.
  3. b > r and b > g → B.
  4. g > r and g ≥ b → G.
  5. 4·g ≥ 3·r → Y.
  6. 2·g ≥ r → O.
  7. Otherwise → R.
- Products are 10-bit unsigned with no truncation.
- FSM states: IDLE, SETTLE, SAMPLE, REPORT.
  - IDLE: no action; `motors_done` → SETTLE with the settle counter cleared.
  - SETTLE: counter increments each clock; on reaching SETTLE_CYCLES−1 → SAMPLE with match and sample counters cleared.
  - SAMPLE: every `sample_valid` cycle registers the class pair (stage 1). Stage 2 then updates the match count:
    - either class invalid → match count = 0;
    - pair equals the stored reference pair and match count > 0 → match count + 1;
    - otherwise → reference = pair, match count = 1.
    - Every accepted sample, valid or not, increments the sample count.
  - Match count reaching STABLE_COUNT → REPORT. The reference pair is latched onto the outputs and `color_sensor_stable` pulses.
  - Sample count reaching MAX_SAMPLES without success → REPORT. The last registered pair is latched (may contain 7), `sensor_fault` is set, and `color_sensor_stable` still pulses.
  - REPORT: lasts exactly one cycle, then → IDLE.
- `motors_done` in any state (including mid-SETTLE, mid-SAMPLE, or REPORT) restarts SETTLE, clears `sensor_fault`, and drops any pending pulse. The output color registers keep their old values.
- `sample_valid` outside SAMPLE is ignored.

## Timing
- Reset values: both color outputs 3'd0, `color_sensor_stable` 0, `sensor_fault` 0, state IDLE, all counters 0.
- `motors_done` at edge t → first sample accepted at edge t+SETTLE_CYCLES+1 or later.
- Final qualifying sample taken at edge k → outputs and `color_sensor_stable` high in the cycle after edge k+2. The pulse lasts exactly one cycle.
- Minimum latency with back-to-back `sample_valid` is SETTLE_CYCLES+STABLE_COUNT+3 clocks.
- A `sample_valid` arriving while the state transitions to REPORT is discarded.
- Deasserting `reset_n` at any time returns all state to reset values asynchronously.

## Test plan
- SETTLE_CYCLES=8, STABLE_COUNT=4: `motors_done`, then 4 back-to-back samples of edge (200,30,30) and corner (30,30,200) → single pulse with edge=3 (R), corner=4 (B), `sensor_fault`=0.
- Classification sweep on edge with corner fixed: (220,220,220)→W; (200,160,20)→Y; (200,110,20)→O; (20,200,20)→G; (10,10,10) never reports while repeated; a tie (100,100,100) below WHITE_MIN→Y.
- Matching sequence G,G,R,R,R,R on edge → pulse only after the sixth sample, edge=3. An inserted dark sample mid-run restarts the count.
- MAX_SAMPLES=8 with alternating R/B samples → after the eighth sample, pulse with `sensor_fault`=1. The next `motors_done` clears the fault.
- `motors_done` during SAMPLE after 3 matches → no pulse, full SETTLE_CYCLES wait again, then 4 fresh matches are required.
- `reset_n` asserted low mid-SETTLE → outputs immediately 0, state IDLE. `sample_valid` without `motors_done` produces no pulse.
